// File: rtl/sine_filt.sv
// sine_filt: 21-tap symmetric low-pass FIR, 1s17 in/out, unity DC gain.
// Pipeline: delay line -> pre-add -> multiply -> sum/scale/saturate.
module sine_filt (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [17:0] x_in,
  output logic signed [17:0] y
);

  localparam logic signed [17:0] H [0:10] = '{
    -18'sd512,  -18'sd768,  -18'sd512,  18'sd512,
    18'sd2048,  18'sd3584,  18'sd5632,  18'sd9216,
    18'sd16384, 18'sd18432, 18'sd23040
  };

  localparam logic signed [41:0] YMAX = 42'sd131071;
  localparam logic signed [41:0] YMIN = -42'sd131072;

  logic signed [17:0] xd [0:20];
  logic signed [18:0] pa [0:10];
  logic signed [36:0] pr [0:10];
  logic signed [41:0] acc;
  logic signed [41:0] sh;
  logic signed [17:0] ysat;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 21; k++) xd[k] <= '0;
    end else begin
      xd[0] <= x_in;
      for (int k = 1; k < 21; k++) xd[k] <= xd[k-1];
    end
  end

  // fold mirrored taps; centre tap passes through sign-extended
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 11; k++) pa[k] <= '0;
    end else begin
      for (int k = 0; k < 10; k++)
        pa[k] <= {xd[k][17], xd[k]} + {xd[20-k][17], xd[20-k]};
      pa[10] <= {xd[10][17], xd[10]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 11; k++) pr[k] <= '0;
    end else begin
      for (int k = 0; k < 11; k++)
        pr[k] <= $signed({{18{pa[k][18]}}, pa[k]})
               * $signed({{19{H[k][17]}}, H[k]});
    end
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < 11; k++)
      acc = acc + $signed({{5{pr[k][36]}}, pr[k]});
    sh = acc >>> 17;
    ysat = sh[17:0];
    if (sh > YMAX)      ysat = 18'sd131071;
    else if (sh < YMIN) ysat = -18'sd131072;
  end

  always_ff @(posedge clk) begin
    if (reset) y <= '0;
    else       y <= ysat;
  end

endmodule

// File: tb/tb_sine_filt.sv
// tb_sine_filt: directed + random checks of sine_filt
// against a direct-convolution reference model.
module tb_sine_filt;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [17:0] x_in;
  logic signed [17:0] y;

  always #5 clk = ~clk;

  sine_filt dut (
    .clk   (clk),
    .reset (reset),
    .x_in  (x_in),
    .y     (y)
  );

  int total = 0;
  int bad = 0;

  int h [0:20] = '{
    -512, -768, -512, 512, 2048, 3584, 5632, 9216, 16384, 18432, 23040,
    18432, 16384, 9216, 5632, 3584, 2048, 512, -512, -768, -512
  };
  int imp [0:20] = '{
    -256, -384, -256, 256, 1024, 1792, 2816, 4608, 8192, 9216, 11520,
    9216, 8192, 4608, 2816, 1792, 1024, 256, -256, -384, -256
  };

  longint hist [0:20];
  longint pipe [0:2];
  longint yexp;
  longint ramp1 [0:29];

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // y after edge m is the clamped, floored convolution of the
  // accepted-sample window as it stood three edges earlier
  task automatic model_edge();
    longint s;
    if (reset) begin
      for (int k = 0; k < 21; k++) hist[k] = 0;
      for (int k = 0; k < 3; k++) pipe[k] = 0;
      yexp = 0;
    end else begin
      for (int k = 20; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = x_in;
      yexp = pipe[2];
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      s = 0;
      for (int k = 0; k < 21; k++) s += h[k] * hist[k];
      s = s >>> 17;
      if (s > 131071) s = 131071;
      if (s < -131072) s = -131072;
      pipe[0] = s;
    end
  endtask

  task automatic step(input string tag, input logic signed [17:0] xv,
                      input logic r);
    x_in = xv;
    reset = r;
    @(posedge clk);
    model_edge();
    #1;
    chk(tag, y, yexp);
  endtask

  initial begin
    logic signed [17:0] xv;
    real ph;
    x_in = '0;
    reset = 1'b1;

    for (int i = 0; i < 21; i++) begin
      step("rst_model", 18'($urandom), 1'b1);
      chk("rst_zero", y, 0);
    end
    for (int i = 0; i < 3; i++) begin
      step("post_rst_model", 18'sd0, 1'b0);
      chk("post_rst_zero", y, 0);
    end

    for (int i = 0; i < 27; i++) begin
      step("imp_model", (i == 0) ? 18'sd65536 : 18'sd0, 1'b0);
      if (i >= 3 && i <= 23) chk("imp", y, imp[i-3]);
      else if (i > 23) chk("imp_tail", y, 0);
    end

    step("dc_rst", 18'sd0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      step("dc_model", 18'sd65536, 1'b0);
      ramp1[i] = yexp;
      if (i >= 23) chk("dc_settle", y, 65536);
    end
    step("mid_rst_model", 18'sd65536, 1'b1);
    chk("mid_rst_zero", y, 0);
    for (int i = 0; i < 30; i++) begin
      step("dc2_model", 18'sd65536, 1'b0);
      chk("ramp_repeat", y, ramp1[i]);
    end

    step("ndc_rst", 18'sd0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      step("ndc_model", -18'sd131072, 1'b0);
      if (i >= 23) chk("ndc_settle", y, -131072);
    end

    step("wc_rst", 18'sd0, 1'b1);
    for (int i = 0; i < 21; i++)
      step("wc_model", (h[20-i] > 0) ? 18'sd131071 : -18'sd131072, 1'b0);
    for (int i = 0; i < 3; i++) step("wc_model", 18'sd0, 1'b0);
    chk("wc_pos_sat", y, 131071);

    step("wcn_rst", 18'sd0, 1'b1);
    for (int i = 0; i < 21; i++)
      step("wcn_model", (h[20-i] > 0) ? -18'sd131072 : 18'sd131071, 1'b0);
    for (int i = 0; i < 3; i++) step("wcn_model", 18'sd0, 1'b0);
    chk("wc_neg_sat", y, -131072);

    step("sine_rst", 18'sd0, 1'b1);
    for (int n = 0; n < 256; n++) begin
      ph = 2.0 * 3.14159265358979 * n / 64.0;
      xv = 18'($rtoi($floor(100000.0 * $sin(ph) + 0.5)));
      step("sine", xv, 1'b0);
    end

    step("rand_rst", 18'sd0, 1'b1);
    for (int i = 0; i < 500; i++)
      step("rand", 18'($urandom), ($urandom_range(0, 39) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
